// File: rtl/serv_irq_ctrl.sv
// Machine-level interrupt controller and trap-entry cause streamer for the serial core.
// Define SERV_IRQ_SYNC_EN to pass the interrupt sources through two-flop synchronizers.
module serv_irq_ctrl #(
    parameter int W              = 1,
    parameter int B              = W - 1,
    parameter     RESET_STRATEGY = "MINI"
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_meip,
    input  logic       i_msip,
    input  logic       i_mtip,
    input  logic       i_meie,
    input  logic       i_msie,
    input  logic       i_mtie,
    input  logic       i_mstatus_mie,
    output logic       o_irq_req,
    input  logic       i_irq_ack,
    input  logic       i_mret,
    input  logic       i_en,
    input  logic       i_cnt0to3,
    input  logic       i_cause_rd,
    output logic [B:0] o_cause,
    output logic       o_cause31,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        CAUSE   = 2'd2,
        SERVICE = 2'd3
    } state_t;

    localparam bit RST_ALL = (RESET_STRATEGY != "NONE");

    // Vector bit order throughout: [2] external, [1] software, [0] timer.
    state_t     state_r;
    logic [2:0] src_s;
    logic [2:0] q_s;
    logic [2:0] pend_r;
    logic [2:0] clr_s;
    logic [2:0] sel_r;
    logic [3:0] code_r;
    logic [1:0] cnt_r;
    logic       stream_s;
    logic       last_s;
    logic [B:0] chunk_s;

    // Fixed priority: external > software > timer, one-hot result.
    function automatic logic [2:0] pick_sel(input logic [2:0] p);
        logic [2:0] s;
        if (p[2]) begin
            s = 3'b100;
        end else if (p[1]) begin
            s = 3'b010;
        end else if (p[0]) begin
            s = 3'b001;
        end else begin
            s = 3'b000;
        end
        return s;
    endfunction

    function automatic logic [3:0] sel_code(input logic [2:0] s);
        logic [3:0] c;
        case (s)
            3'b100:  c = 4'd11;
            3'b010:  c = 4'd3;
            3'b001:  c = 4'd7;
            default: c = 4'd0;
        endcase
        return c;
    endfunction

`ifdef SERV_IRQ_SYNC_EN
    logic [2:0] sync1_r;
    logic [2:0] sync2_r;

    // Two-flop synchronizers for the asynchronous interrupt lines.
    always_ff @(posedge i_clk) begin
        if (RST_ALL && i_rst) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= {i_meip, i_msip, i_mtip};
            sync2_r <= sync1_r;
        end
    end

    assign src_s = sync2_r;
`else
    assign src_s = {i_meip, i_msip, i_mtip};
`endif

    assign q_s      = src_s & {i_meie, i_msie, i_mtie};
    assign stream_s = (state_r == CAUSE) & i_cause_rd & i_en & i_cnt0to3;
    assign last_s   = (W == 1) ? (cnt_r == 2'd3) : 1'b1;

    generate
        if (W == 1) begin : g_w1
            assign chunk_s = code_r[cnt_r];
        end else if (W == 4) begin : g_w4
            assign chunk_s = code_r;
        end else begin : g_wide
            assign chunk_s = {{(W - 4){1'b0}}, code_r};
        end
    endgenerate

    // Pending clear for the source being acknowledged.
    always_comb begin
        clr_s = 3'b000;
        if ((state_r == REQ) && i_irq_ack) begin
            clr_s = sel_r;
        end else begin
            clr_s = 3'b000;
        end
    end

    // Sticky pending bits; a new set and an ack clear of another source coexist.
    always_ff @(posedge i_clk) begin
        if (RST_ALL && i_rst) begin
            pend_r <= 3'b000;
        end else begin
            pend_r <= (pend_r | q_s) & ~clr_s;
        end
    end

    // Trap-entry FSM with its registered request/busy outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= IDLE;
            o_irq_req <= 1'b0;
            o_busy    <= 1'b0;
            if (RST_ALL) begin
                sel_r  <= 3'b000;
                code_r <= 4'd0;
                cnt_r  <= 2'd0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_mstatus_mie && (|pend_r)) begin
                        state_r   <= REQ;
                        o_irq_req <= 1'b1;
                        o_busy    <= 1'b1;
                        sel_r     <= pick_sel(pend_r);
                        code_r    <= sel_code(pick_sel(pend_r));
                    end
                end
                REQ: begin
                    if (i_irq_ack) begin
                        state_r   <= CAUSE;
                        o_irq_req <= 1'b0;
                        cnt_r     <= 2'd0;
                    end else if (!i_mstatus_mie) begin
                        state_r   <= IDLE;
                        o_irq_req <= 1'b0;
                        o_busy    <= 1'b0;
                    end
                end
                CAUSE: begin
                    if (stream_s) begin
                        if (last_s) begin
                            state_r <= SERVICE;
                            cnt_r   <= 2'd0;
                        end else begin
                            cnt_r <= cnt_r + 2'd1;
                        end
                    end
                end
                SERVICE: begin
                    if (i_mret) begin
                        state_r <= IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    o_irq_req <= 1'b0;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Cause bits are presented only in the cycles the core consumes them.
    always_comb begin
        if (stream_s) begin
            o_cause = chunk_s;
        end else begin
            o_cause = {W{1'b0}};
        end
    end

    assign o_cause31 = (state_r == CAUSE) & i_cause_rd;

endmodule

// File: tb/tb_serv_irq_ctrl.sv
// Scoreboard bench for serv_irq_ctrl: three instances (W=1, 4, 8) exercised one at a time.
module tb_serv_irq_ctrl;

`ifdef SERV_IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst, meip, msip, mtip, meie, msie, mtie, gie;
    logic [2:0] ack, mret, en, cnt03, crd;
    wire  [2:0] req, busy, c31;
    wire  [7:0] cause_w [3];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int WW = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
            wire [WW-1:0] cause_s;
            serv_irq_ctrl #(.W(WW)) dut (
                .i_clk         (clk),
                .i_rst         (rst[g]),
                .i_meip        (meip[g]),
                .i_msip        (msip[g]),
                .i_mtip        (mtip[g]),
                .i_meie        (meie[g]),
                .i_msie        (msie[g]),
                .i_mtie        (mtie[g]),
                .i_mstatus_mie (gie[g]),
                .o_irq_req     (req[g]),
                .i_irq_ack     (ack[g]),
                .i_mret        (mret[g]),
                .i_en          (en[g]),
                .i_cnt0to3     (cnt03[g]),
                .i_cause_rd    (crd[g]),
                .o_cause       (cause_s),
                .o_cause31     (c31[g]),
                .o_busy        (busy[g])
            );
            assign cause_w[g] = 8'(cause_s);
        end
    endgenerate

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int d);
        int n = 0;
        while (!req[d] && n < 20) begin
            cyc();
            n++;
        end
        check("req_up", 8'(req[d]), 8'd1);
    endtask

    // Take one interrupt: ack, stream the cause, compare against the scoreboard, mret.
    task automatic serve(input int d, input logic [3:0] code);
        logic [7:0] got;
        int chunks;
        wait_req(d);
        check("busy_in_req", 8'(busy[d]), 8'd1);
        exp_q.push_back({4'b0000, code});
        ack[d] = 1'b1;
        cyc();
        ack[d] = 1'b0;
        check("req_after_ack", 8'(req[d]), 8'd0);
        crd[d] = 1'b1; en[d] = 1'b0; cnt03[d] = 1'b1;
        #1;
        check("cause_stalled", cause_w[d], 8'd0);
        check("cause31", 8'(c31[d]), 8'd1);
        chunks = (d == 0) ? 4 : 1;
        got = 8'd0;
        for (int k = 0; k < chunks; k++) begin
            en[d] = 1'b1;
            #1;
            if (d == 0) got[k] = cause_w[d][0];
            else        got = cause_w[d];
            cyc();
        end
        en[d] = 1'b0; crd[d] = 1'b0; cnt03[d] = 1'b0;
        check("cause_code", got, exp_q.pop_front());
        check("busy_service", 8'(busy[d]), 8'd1);
        mret[d] = 1'b1;
        cyc();
        mret[d] = 1'b0;
        check("busy_after_mret", 8'(busy[d]), 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 3'b111;
        {meip, msip, mtip, meie, msie, mtie, gie} = '0;
        {ack, mret, en, cnt03, crd} = '0;
        cyc();
        cyc();
        for (int d = 0; d < 3; d++) begin
            check("rst_req", 8'(req[d]), 8'd0);
            check("rst_busy", 8'(busy[d]), 8'd0);
            check("rst_cause", cause_w[d], 8'd0);
            check("rst_cause31", 8'(c31[d]), 8'd0);
        end
        rst = 3'b000;
        gie = 3'b111;

        // W=1 timer: latency, then cause bits 1,1,1,0
        mtie[0] = 1'b1;
        mtip[0] = 1'b1;
        cyc();
        mtip[0] = 1'b0;
        check("lat_req_low", 8'(req[0]), 8'd0);
        for (int i = 2; i < LAT; i++) begin
            cyc();
            check("lat_req_low", 8'(req[0]), 8'd0);
        end
        cyc();
        check("lat_req_high", 8'(req[0]), 8'd1);
        serve(0, 4'd7);

        // W=4: all sources together, priority order 11, 3, 7
        {meie[1], msie[1], mtie[1]} = 3'b111;
        {meip[1], msip[1], mtip[1]} = 3'b111;
        cyc();
        {meip[1], msip[1], mtip[1]} = 3'b000;
        serve(1, 4'd11);
        serve(1, 4'd3);
        serve(1, 4'd7);
        for (int i = 0; i < LAT + 3; i++) cyc();
        check("all_drained_req", 8'(req[1]), 8'd0);
        check("all_drained_busy", 8'(busy[1]), 8'd0);

        // Global enable dropped while requesting
        mtip[1] = 1'b1;
        cyc();
        mtip[1] = 1'b0;
        wait_req(1);
        gie[1] = 1'b0;
        cyc();
        check("withdraw_req", 8'(req[1]), 8'd0);
        check("withdraw_busy", 8'(busy[1]), 8'd0);
        for (int i = 0; i < 3; i++) cyc();
        check("withdraw_hold", 8'(req[1]), 8'd0);
        gie[1] = 1'b1;
        serve(1, 4'd7);

        // Sticky software pulse, then masked pulse ignored
        msie[0] = 1'b1;
        msip[0] = 1'b1;
        cyc();
        msip[0] = 1'b0;
        serve(0, 4'd3);
        msie[0] = 1'b0;
        msip[0] = 1'b1;
        cyc();
        msip[0] = 1'b0;
        for (int i = 0; i < LAT + 3; i++) cyc();
        check("masked_pulse", 8'(req[0]), 8'd0);

        // W=8: reset in the middle of CAUSE with another source pending
        {meie[2], msie[2], mtie[2]} = 3'b111;
        meip[2] = 1'b1;
        cyc();
        meip[2] = 1'b0;
        wait_req(2);
        ack[2] = 1'b1;
        cyc();
        ack[2] = 1'b0;
        mtip[2] = 1'b1;
        cyc();
        mtip[2] = 1'b0;
        for (int i = 0; i < LAT + 1; i++) cyc();
        crd[2] = 1'b1; en[2] = 1'b1; cnt03[2] = 1'b1;
        #1;
        check("w8_cause", cause_w[2], 8'd11);
        check("w8_cause31", 8'(c31[2]), 8'd1);
        rst[2] = 1'b1;
        cyc();
        rst[2] = 1'b0;
        check("midrst_busy", 8'(busy[2]), 8'd0);
        check("midrst_req", 8'(req[2]), 8'd0);
        check("midrst_cause", cause_w[2], 8'd0);
        check("midrst_cause31", 8'(c31[2]), 8'd0);
        crd[2] = 1'b0; en[2] = 1'b0; cnt03[2] = 1'b0;
        for (int i = 0; i < LAT + 3; i++) cyc();
        check("midrst_pend_clear", 8'(req[2]), 8'd0);

        // Stray ack and mret in IDLE
        ack[0] = 1'b1;
        mret[0] = 1'b1;
        cyc();
        ack[0] = 1'b0;
        mret[0] = 1'b0;
        cyc();
        check("stray_busy", 8'(busy[0]), 8'd0);
        check("stray_req", 8'(req[0]), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
